// File: rtl/lrck_format_ctrl_pkg.sv
// Shared types and constants for the LRCK format controller: format codes,
// BCK-per-half-frame ratios and controller state encoding.
package lrck_format_ctrl_pkg;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_32   = 2'd1,
    FMT_48   = 2'd2,
    FMT_64   = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED,
    MUTING
  } state_e;

  localparam logic [7:0] BCK_32FS = 8'd16;
  localparam logic [7:0] BCK_48FS = 8'd24;
  localparam logic [7:0] BCK_64FS = 8'd32;

  function automatic fmt_e classify(input logic [7:0] m);
    case (m)
      BCK_32FS: return FMT_32;
      BCK_48FS: return FMT_48;
      BCK_64FS: return FMT_64;
      default:  return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lrck_period_meter.sv
// Counts BCK cycles between LRCK edges, classifies each half-frame length and
// strobes a timeout when LRCK has been static for TIMEOUT cycles.
module lrck_period_meter
  import lrck_format_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic bck,
  input  logic rst_n,
  input  logic lrck,
  output logic lrck_edge,
  output logic m_valid,
  output fmt_e m_code,
  output logic timeout
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic       lrck_d;
  logic [7:0] hp_cnt;

  assign lrck_edge = lrck ^ lrck_d;
  assign m_code    = classify(hp_cnt);
  assign m_valid   = lrck_edge && (m_code != FMT_NONE);
  // An edge restarts the count, so it takes priority over a coincident timeout.
  assign timeout   = !lrck_edge && (hp_cnt == TimeoutCnt);

  always_ff @(posedge bck or negedge rst_n) begin
    if (!rst_n) begin
      lrck_d <= 1'b0;
      hp_cnt <= 8'd0;
    end else begin
      lrck_d <= lrck;
      if (lrck_edge) begin
        hp_cnt <= 8'd1;
      end else if (hp_cnt != 8'hff) begin
        hp_cnt <= hp_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/lrck_format_ctrl.sv
// Format lock controller: acquires a stable LRCK ratio, enables and aligns the
// downstream converter, releases mute, and tears down cleanly on loss of lock.
module lrck_format_ctrl
  import lrck_format_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_HF   = 8,
  parameter int unsigned UNMUTE_HF = 4,
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned MUTE_HOLD = 64
) (
  input  logic       bck,
  input  logic       rst_n,
  input  logic       lrck,
  output logic [1:0] fmt,
  output logic       fmt_valid,
  output logic       conv_en,
  output logic       conv_sync,
  output logic       mute,
  output logic       err_pulse
);

  localparam logic [7:0] LockHf   = 8'(LOCK_HF);
  localparam logic [7:0] UnmuteHf = 8'(UNMUTE_HF);
  localparam logic [7:0] HoldLast = 8'(MUTE_HOLD - 1);

  logic       lrck_edge;
  logic       m_valid;
  fmt_e       m_code;
  logic       timeout;

  state_e     state;
  fmt_e       candidate;
  logic [7:0] match_cnt;
  logic [7:0] match_nxt;
  logic [7:0] unmute_cnt;
  logic [7:0] hold_cnt;
  logic       first_edge;

  lrck_period_meter #(
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .bck       (bck),
    .rst_n     (rst_n),
    .lrck      (lrck),
    .lrck_edge (lrck_edge),
    .m_valid   (m_valid),
    .m_code    (m_code),
    .timeout   (timeout)
  );

  always_comb begin
    match_nxt = (m_code == candidate) ? match_cnt + 8'd1 : 8'd1;
  end

  always_ff @(posedge bck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fmt        <= FMT_NONE;
      fmt_valid  <= 1'b0;
      conv_en    <= 1'b0;
      conv_sync  <= 1'b0;
      mute       <= 1'b1;
      err_pulse  <= 1'b0;
      candidate  <= FMT_NONE;
      match_cnt  <= 8'd0;
      unmute_cnt <= 8'd0;
      hold_cnt   <= 8'd0;
      first_edge <= 1'b1;
    end else begin
      conv_sync <= 1'b0;
      err_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lrck_edge) begin
            state      <= MEASURE;
            first_edge <= 1'b0;
          end
        end
        MEASURE: begin
          if (lrck_edge) begin
            if (first_edge) begin
              first_edge <= 1'b0;
            end else if (!m_valid) begin
              match_cnt <= 8'd0;
            end else begin
              candidate <= m_code;
              if (match_nxt == LockHf) begin
                state      <= LOCKED;
                fmt        <= m_code;
                fmt_valid  <= 1'b1;
                conv_en    <= 1'b1;
                conv_sync  <= 1'b1;
                unmute_cnt <= 8'd0;
                match_cnt  <= 8'd0;
              end else begin
                match_cnt <= match_nxt;
              end
            end
          end else if (timeout) begin
            match_cnt  <= 8'd0;
            first_edge <= 1'b1;
          end
        end
        LOCKED: begin
          if ((lrck_edge && (!m_valid || m_code != fmt)) || timeout) begin
            state     <= MUTING;
            mute      <= 1'b1;
            err_pulse <= 1'b1;
            fmt_valid <= 1'b0;
            hold_cnt  <= 8'd0;
          end else if (lrck_edge) begin
            if (unmute_cnt < UnmuteHf) begin
              unmute_cnt <= unmute_cnt + 8'd1;
            end
            if (unmute_cnt + 8'd1 >= UnmuteHf) begin
              mute <= 1'b0;
            end
          end
        end
        MUTING: begin
          // Converter stays enabled while the output ramps down under mute.
          if (hold_cnt == HoldLast) begin
            state      <= MEASURE;
            conv_en    <= 1'b0;
            fmt        <= FMT_NONE;
            match_cnt  <= 8'd0;
            first_edge <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lrck_format_ctrl.sv
// Randomised and directed scenarios for lrck_format_ctrl; a time-stamped event
// model predicts lock/unmute/error/disable events checked by a monitor.
module tb_lrck_format_ctrl;

  localparam int LOCK_HF   = 8;
  localparam int UNMUTE_HF = 4;
  localparam int TIMEOUT   = 200;
  localparam int MUTE_HOLD = 64;

  localparam int EV_LOCK    = 0;
  localparam int EV_UNMUTE  = 1;
  localparam int EV_ERR     = 2;
  localparam int EV_DISABLE = 3;

  typedef struct {
    int kind;
    int t;
    int f;
  } ev_t;

  logic       bck = 1'b0;
  logic       rst_n = 1'b0;
  logic       lrck = 1'b0;
  logic [1:0] fmt;
  logic       fmt_valid;
  logic       conv_en;
  logic       conv_sync;
  logic       mute;
  logic       err_pulse;

  int  n_checks = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  int  edges[$];
  int  last_t;
  int  t_end;
  int  fin_conv_en, fin_fmt_valid, fin_fmt, fin_mute;

  lrck_format_ctrl #(
    .LOCK_HF   (LOCK_HF),
    .UNMUTE_HF (UNMUTE_HF),
    .TIMEOUT   (TIMEOUT),
    .MUTE_HOLD (MUTE_HOLD)
  ) dut (
    .bck       (bck),
    .rst_n     (rst_n),
    .lrck      (lrck),
    .fmt       (fmt),
    .fmt_valid (fmt_valid),
    .conv_en   (conv_en),
    .conv_sync (conv_sync),
    .mute      (mute),
    .err_pulse (err_pulse)
  );

  always #5 bck = ~bck;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int t, input int f);
    ev_t e;
    e.kind = kind;
    e.t    = t;
    e.f    = f;
    exp_q.push_back(e);
  endtask

  // Edge at cycle t means the DUT sees lrck differ from its previous sample at posedge t.
  task automatic new_plan(input int first);
    edges.delete();
    last_t = first;
    edges.push_back(first);
  endtask

  task automatic add_halves(input int n, input int len);
    for (int i = 0; i < n; i++) begin
      last_t += len;
      edges.push_back(last_t);
    end
  endtask

  function automatic int code_of(input int m);
    if (m == 16) return 1;
    if (m == 24) return 2;
    if (m == 32) return 3;
    return 0;
  endfunction

  // Walks the edge timestamps; between edges, applies the timeout and mute-hold expiry.
  task automatic model_run();
    int  mode = 0;  // 0 idle, 1 measuring, 2 locked, 3 muting
    int  prev = 0;
    bit  to_done = 0;
    bit  disc = 0;
    int  cand = 0, cnt = 0, lf = 0, un = 0;
    bit  muted = 1;
    int  mute_end = 0;
    for (int k = 0; k <= edges.size(); k++) begin
      int te;
      int m;
      int code;
      te = (k < edges.size()) ? edges[k] : t_end + 1;
      forever begin
        int tt;
        tt = prev + TIMEOUT;
        if (!to_done && tt < te && !(mode == 3 && mute_end < tt)) begin
          to_done = 1;
          if (mode == 1) begin
            cnt  = 0;
            disc = 1;
          end else if (mode == 2) begin
            push_ev(EV_ERR, tt, lf);
            mode     = 3;
            mute_end = tt + MUTE_HOLD;
          end
        end else if (mode == 3 && mute_end < te) begin
          push_ev(EV_DISABLE, mute_end, 0);
          mode  = 1;
          disc  = 1;
          cnt   = 0;
          lf    = 0;
          muted = 1;
        end else begin
          break;
        end
      end
      if (k == edges.size()) break;
      m = te - prev;
      if (m > 255) m = 255;
      prev    = te;
      to_done = 0;
      code    = code_of(m);
      case (mode)
        0: begin
          mode = 1;
          disc = 0;
        end
        1: begin
          if (disc) begin
            disc = 0;
          end else if (code == 0) begin
            cnt = 0;
          end else begin
            if (code == cand) cnt++;
            else begin
              cand = code;
              cnt  = 1;
            end
            if (cnt == LOCK_HF) begin
              push_ev(EV_LOCK, te, code);
              mode  = 2;
              lf    = code;
              un    = 0;
              muted = 1;
              cnt   = 0;
            end
          end
        end
        2: begin
          if (code == lf) begin
            un++;
            if (un >= UNMUTE_HF && muted) begin
              push_ev(EV_UNMUTE, te, lf);
              muted = 0;
            end
          end else begin
            push_ev(EV_ERR, te, lf);
            mode     = 3;
            mute_end = te + MUTE_HOLD;
          end
        end
        default: ;
      endcase
    end
    fin_conv_en   = (mode >= 2) ? 1 : 0;
    fin_fmt_valid = (mode == 2) ? 1 : 0;
    fin_fmt       = (mode >= 2) ? lf : 0;
    fin_mute      = (mode == 2) ? int'(muted) : 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fmt"}, fmt, 0);
    chk({tag, "_fmt_valid"}, fmt_valid, 0);
    chk({tag, "_conv_en"}, conv_en, 0);
    chk({tag, "_conv_sync"}, conv_sync, 0);
    chk({tag, "_mute"}, mute, 1);
    chk({tag, "_err_pulse"}, err_pulse, 0);
  endtask

  task automatic got_ev(input int kind, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, c);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", c, e.t);
      chk("event_fmt", fmt, e.f);
    end
  endtask

  task automatic drive();
    int cur = -1;
    foreach (edges[i]) begin
      repeat (edges[i] - 1 - cur) @(negedge bck);
      cur  = edges[i] - 1;
      lrck = ~lrck;
    end
  endtask

  task automatic monitor();
    bit mute_p = 1'b1;
    bit en_p = 1'b0;
    for (int c = 0; c <= t_end; c++) begin
      @(negedge bck);
      if (conv_sync && err_pulse) chk("sync_err_overlap", 1, 0);
      if (conv_sync) begin
        got_ev(EV_LOCK, c);
        chk("lock_fmt_valid", fmt_valid, 1);
        chk("lock_conv_en", conv_en, 1);
        chk("lock_mute", mute, 1);
      end
      if (mute_p && !mute) got_ev(EV_UNMUTE, c);
      if (err_pulse) begin
        got_ev(EV_ERR, c);
        chk("err_fmt_valid", fmt_valid, 0);
        chk("err_mute", mute, 1);
        chk("err_conv_en", conv_en, 1);
      end
      if (en_p && !conv_en) got_ev(EV_DISABLE, c);
      mute_p = mute;
      en_p   = conv_en;
    end
  endtask

  task automatic run_scn(input string tag);
    rst_n = 1'b0;
    lrck  = 1'b0;
    repeat (2) @(posedge bck);
    #1;
    check_reset_outputs({tag, "_rst"});
    exp_q.delete();
    model_run();
    @(negedge bck);
    rst_n = 1'b1;
    fork
      drive();
      monitor();
    join
    chk({tag, "_leftover_events"}, exp_q.size(), 0);
    chk({tag, "_final_conv_en"}, conv_en, fin_conv_en);
    chk({tag, "_final_fmt_valid"}, fmt_valid, fin_fmt_valid);
    chk({tag, "_final_fmt"}, fmt, fin_fmt);
    chk({tag, "_final_mute"}, mute, fin_mute);
  endtask

  task automatic random_plan();
    new_plan(int'($urandom_range(1, 40)));
    for (int s = 0; s < 12; s++) begin
      int r;
      r = int'($urandom_range(0, 5));
      case (r)
        0: add_halves(int'($urandom_range(1, 14)), 16);
        1: add_halves(int'($urandom_range(1, 14)), 24);
        2: add_halves(int'($urandom_range(1, 14)), 32);
        3: add_halves(int'($urandom_range(1, 3)), int'($urandom_range(10, 40)));
        4: add_halves(1, int'($urandom_range(150, 300)));
        default: add_halves(int'($urandom_range(8, 14)), 32);
      endcase
    end
    t_end = last_t + int'($urandom_range(10, 300));
  endtask

  initial begin
    // 64fs lock, then asynchronous reset while locked and unmuted
    new_plan(5);
    add_halves(30, 32);
    t_end = last_t + 10;
    run_scn("lock64");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");

    // 48fs with one 25-cycle half resetting the match run
    new_plan(3);
    add_halves(4, 24);
    add_halves(1, 25);
    add_halves(20, 24);
    t_end = last_t + 10;
    run_scn("fmt48");

    // Format change from 64fs to 32fs
    new_plan(7);
    add_halves(20, 32);
    add_halves(25, 16);
    t_end = last_t + 10;
    run_scn("fmtchg");

    // LRCK loss after lock
    new_plan(2);
    add_halves(20, 32);
    t_end = last_t + 600;
    run_scn("loss");

    // Invalid ratio forever
    new_plan(4);
    add_halves(40, 20);
    t_end = last_t + 10;
    run_scn("invalid");

    for (int i = 0; i < 4; i++) begin
      random_plan();
      run_scn($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
